exe_operand_issue: RTL
======================

Name: exe_operand_issue

Overview:
- ID-stage issue block that produces the EXE-stage ALU inputs: operand A, operand B and the 4-bit aluc code.
- Decodes the instruction in ID and selects forwarded operands.
- Detects load-use hazards, stalls the front end, and inserts bubbles.
- Holds the ID/EXE pipeline register, so its registered outputs drive the ALU directly.

Parameters:
- None. Datapath is fixed at 32 bits, register numbers at 5 bits.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst  in  32  instruction in ID stage.
- qa  in  32  register file read data for rs.
- qb  in  32  register file read data for rt.
- exe_r  in  32  ALU result currently in EXE.
- mrn  in  5  destination register in MEM.
- mwreg  in  1  MEM stage writes a register.
- mm2reg  in  1  MEM stage is a load.
- malu  in  32  MEM stage ALU result.
- mmo  in  32  MEM stage load data.
- stall  out  1  combinational; 1 = hold PC and IF/ID this cycle.
- ea  out  32  registered ALU operand A.
- eb  out  32  registered ALU operand B.
- ealuc  out  4  registered ALU control.
- ern  out  5  registered destination register.
- ewreg  out  1  registered register-write enable.
- em2reg  out  1  registered load flag.
- ewmem  out  1  registered store flag.
- estore  out  32  registered store data (forwarded rt).

Behaviour:
- Reset: rst=1 forces ea, eb, ealuc, ern, ewreg, em2reg, ewmem and estore to 0 immediately. These values form a bubble. Reset mid-stream drops the in-flight EXE instruction.
- Latency: one cycle, ID to registered E outputs. Every rising clk (rst=0) loads the decoded instruction, or a bubble when stall=1.
- aluc encoding:
  - add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110
  - sll 0011, srl 0111, sra 1111
  - bit2 = sub/or/lui/right-shift; bit3 = arithmetic shift; bits[1:0] = result group.
- Supported R-type (op=0), by funct:
  - add 100000, sub 100010, and 100100, or 100101, xor 100110
  - sll 000000, srl 000010, sra 000011
  - Destination is rd.
- Supported I-type (destination rt):
  - addi 001000 and lw 100011: add, sign-extended immediate.
  - andi 001100, ori 001101, xori 001110: zero-extended immediate.
  - lui 001111: eb = zero-extended immediate; the ALU performs the shift.
  - sw 101011: add, sign-extended immediate, ewreg=0, ewmem=1.
- Any other op/funct decodes as a NOP: bubble values, no stall contribution.
- Operand A:
  - Shifts: ea = {27'b0, shamt}.
  - Otherwise: forwarded rs.
- Operand B:
  - R-type: forwarded rt.
  - I-type: the extended immediate.
  - estore: always forwarded rt.
- Forward select per source register s (rs or rt), in priority order:
  1. If ewreg && !em2reg && ern!=0 && ern==s: use exe_r.
  2. Else if mwreg && mrn!=0 && mrn==s: use mmo when mm2reg, else malu.
  3. Else: use qa/qb.
- Register $0 is never forwarded.
- Usage flags:
  - rs is used by all supported non-shift instructions except lui.
  - rt is used by R-type and by sw.
- Load-use stall: stall = ewreg && em2reg && ern!=0 && ((uses_rs && ern==rs) || (uses_rt && ern==rt)).
- On stall, the ID/EXE register loads a bubble. The same instruction re-decodes next cycle and then forwards from MEM (mmo).
- Destination $0: ewreg is forced to 0 when the decoded destination is 0.
- Simultaneous EXE and MEM match on the same register: EXE wins.
- A stall has no effect on MEM-stage inputs.

Test Plan:
- Reset: assert rst mid-cycle with valid outputs → all registered outputs become 0 immediately, stall=0.
- Decode sweep: each supported instruction with qa=5, qb=3, imm=0xFFFC. Check:
  - sub → ealuc=0100.
  - addi → eb=0xFFFFFFFC.
  - andi → eb=0x0000FFFC.
  - sra rd,rt,4 → ea=4, ealuc=1111.
  - sw → ewmem=1, ewreg=0.
- EXE forward: add $3 in EXE (exe_r=0x1234) while ID holds sub $4,$3,$2 → ea=0x1234 next edge, stall=0.
- MEM forward priority: mrn=3 with malu=0xAAAA and ern=3 with exe_r=0xBBBB, both writing → ea=0xBBBB. Repeat with ewreg=0 → ea=0xAAAA.
- Load-use: lw $5 in EXE, ID holds add $6,$5,$1 → stall=1 for one cycle and E outputs become a bubble. Next cycle, with mm2reg=1 and mmo=0x77 → ea=0x77.
- $0 and unsupported cases:
  - add $0,$1,$2 → ewreg=0.
  - lw to $0 followed by use of $0 → no stall.
  - Unsupported opcode 0x3F → bubble, stall=0.

Source files
------------

// File: rtl/exe_operand_issue.sv
// ID-stage operand issue: decodes the ID instruction, forwards operands from EXE/MEM,
// stalls on load-use hazards and holds the ID/EXE pipeline register feeding the ALU.
module exe_operand_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] qa,
    input  logic [31:0] qb,
    input  logic [31:0] exe_r,
    input  logic [4:0]  mrn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic [31:0] malu,
    input  logic [31:0] mmo,
    output logic        stall,
    output logic [31:0] ea,
    output logic [31:0] eb,
    output logic [3:0]  ealuc,
    output logic [4:0]  ern,
    output logic        ewreg,
    output logic        em2reg,
    output logic        ewmem,
    output logic [31:0] estore
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;

    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign shamt = inst[10:6];
    assign funct = inst[5:0];
    assign imm   = inst[15:0];

    logic       valid;
    logic       is_rtype;
    logic       is_shift;
    logic       sext;
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       uses_rs;
    logic       uses_rt;
    logic [3:0] aluc;

    always_comb begin
        valid    = 1'b0;
        is_rtype = 1'b0;
        is_shift = 1'b0;
        sext     = 1'b0;
        wreg     = 1'b0;
        m2reg    = 1'b0;
        wmem     = 1'b0;
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        aluc     = 4'b0000;
        if (op == 6'b000000) begin
            is_rtype = 1'b1;
            valid    = 1'b1;
            wreg     = 1'b1;
            uses_rs  = 1'b1;
            uses_rt  = 1'b1;
            case (funct)
                6'b100000: aluc = 4'b0000;
                6'b100010: aluc = 4'b0100;
                6'b100100: aluc = 4'b0001;
                6'b100101: aluc = 4'b0101;
                6'b100110: aluc = 4'b0010;
                6'b000000: begin aluc = 4'b0011; is_shift = 1'b1; uses_rs = 1'b0; end
                6'b000010: begin aluc = 4'b0111; is_shift = 1'b1; uses_rs = 1'b0; end
                6'b000011: begin aluc = 4'b1111; is_shift = 1'b1; uses_rs = 1'b0; end
                default: begin
                    valid   = 1'b0;
                    wreg    = 1'b0;
                    uses_rs = 1'b0;
                    uses_rt = 1'b0;
                end
            endcase
        end else begin
            case (op)
                6'b001000: begin valid = 1'b1; wreg = 1'b1; uses_rs = 1'b1; sext = 1'b1; aluc = 4'b0000; end
                6'b100011: begin valid = 1'b1; wreg = 1'b1; uses_rs = 1'b1; sext = 1'b1; m2reg = 1'b1; aluc = 4'b0000; end
                6'b001100: begin valid = 1'b1; wreg = 1'b1; uses_rs = 1'b1; aluc = 4'b0001; end
                6'b001101: begin valid = 1'b1; wreg = 1'b1; uses_rs = 1'b1; aluc = 4'b0101; end
                6'b001110: begin valid = 1'b1; wreg = 1'b1; uses_rs = 1'b1; aluc = 4'b0010; end
                6'b001111: begin valid = 1'b1; wreg = 1'b1; aluc = 4'b0110; end
                6'b101011: begin valid = 1'b1; wmem = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; sext = 1'b1; aluc = 4'b0000; end
                default: ;
            endcase
        end
    end

    logic [4:0]  dest;
    logic [31:0] imm_ext;
    logic [31:0] mem_val;
    logic        ex_hit_a;
    logic        ex_hit_b;
    logic        mem_hit_a;
    logic        mem_hit_b;
    logic [31:0] fa;
    logic [31:0] fb;

    assign dest    = is_rtype ? rd : rt;
    assign imm_ext = sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
    assign mem_val = mm2reg ? mmo : malu;

    // A load in EXE has no result yet, so it is excluded here and handled by the stall.
    assign ex_hit_a  = ewreg && !em2reg && (ern != 5'd0) && (ern == rs);
    assign ex_hit_b  = ewreg && !em2reg && (ern != 5'd0) && (ern == rt);
    assign mem_hit_a = mwreg && (mrn != 5'd0) && (mrn == rs);
    assign mem_hit_b = mwreg && (mrn != 5'd0) && (mrn == rt);

    assign fa = ex_hit_a ? exe_r : (mem_hit_a ? mem_val : qa);
    assign fb = ex_hit_b ? exe_r : (mem_hit_b ? mem_val : qb);

    assign stall = ewreg && em2reg && (ern != 5'd0) &&
                   ((uses_rs && (ern == rs)) || (uses_rt && (ern == rt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ea     <= 32'd0;
            eb     <= 32'd0;
            ealuc  <= 4'd0;
            ern    <= 5'd0;
            ewreg  <= 1'b0;
            em2reg <= 1'b0;
            ewmem  <= 1'b0;
            estore <= 32'd0;
        end else if (stall || !valid) begin
            ea     <= 32'd0;
            eb     <= 32'd0;
            ealuc  <= 4'd0;
            ern    <= 5'd0;
            ewreg  <= 1'b0;
            em2reg <= 1'b0;
            ewmem  <= 1'b0;
            estore <= 32'd0;
        end else begin
            ea     <= is_shift ? {27'd0, shamt} : fa;
            eb     <= is_rtype ? fb : imm_ext;
            ealuc  <= aluc;
            ern    <= wmem ? 5'd0 : dest;
            ewreg  <= wreg && (dest != 5'd0);
            em2reg <= m2reg;
            ewmem  <= wmem;
            estore <= fb;
        end
    end

endmodule
